// File: rtl/sfp_divider_pkg.sv
// Shared fixed-point constants and divider state encoding for the sfp datapath.
package sfp_divider_pkg;

  localparam logic [63:0] SFP_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SFP_MIN = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {
    DIV_IDLE,
    DIV_SETUP,
    DIV_DIVIDE,
    DIV_FIX,
    DIV_DONE
  } sfp_div_state_t;

endpackage

// File: rtl/sfp_divider_step.sv
// One restoring-division iteration: shift in a numerator bit, subtract divisor if it fits.
module sfp_div_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             num_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             qbit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_diff;

  assign w_shift = {rem_in, num_msb};
  assign qbit    = (w_shift >= {2'b00, divisor});
  // Remainder stays below the divisor, so the subtraction fits in WIDTH+1 bits.
  assign w_diff  = w_shift[WIDTH:0] - {1'b0, divisor};
  assign rem_out = qbit ? w_diff : w_shift[WIDTH:0];

endmodule

// File: rtl/sfp_divider.sv
// Sequential signed Q32.32 divider: out_q = (in_a << FRAC_BITS) / in_b, one quotient bit per clock.
module sfp_divider
  import sfp_divider_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned FRAC_BITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             out_ovf,
  output logic             out_dz,
  output logic             busy
);

  localparam int unsigned N  = WIDTH + FRAC_BITS;
  localparam int unsigned CW = $clog2(N);

  sfp_div_state_t r_state, w_next;

  logic [WIDTH-1:0] r_a, r_b, r_bmag;
  logic [N-1:0]     r_num, r_q;
  logic [WIDTH:0]   r_rem, w_rem_next;
  logic [CW-1:0]    r_cnt;
  logic             r_sign, r_dz, w_qbit;
  logic [WIDTH-1:0] w_fix_q;
  logic             w_fix_ovf, w_pos_ovf, w_neg_ovf;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  sfp_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (r_rem),
    .num_msb (r_num[N-1]),
    .divisor (r_bmag),
    .rem_out (w_rem_next),
    .qbit    (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= DIV_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DIV_IDLE:   if (in_valid) w_next = DIV_SETUP;
      DIV_SETUP:  w_next = DIV_DIVIDE;
      DIV_DIVIDE: if (r_cnt == '0) w_next = DIV_FIX;
      DIV_FIX:    w_next = DIV_DONE;
      DIV_DONE:   if (out_ready) w_next = DIV_IDLE;
      default:    w_next = DIV_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == DIV_IDLE) && !rst;
    busy      = (r_state != DIV_IDLE);
    out_valid = (r_state == DIV_DONE);
  end

  // Positive results may reach 2^63-1; negative results may reach 2^63 (SFP_MIN).
  always_comb begin
    w_pos_ovf = |r_q[N-1:WIDTH-1];
    w_neg_ovf = (|r_q[N-1:WIDTH]) || (r_q[WIDTH-1] && (|r_q[WIDTH-2:0]));
    w_fix_ovf = 1'b0;
    w_fix_q   = '0;
    if (r_dz) begin
      w_fix_q = r_a[WIDTH-1] ? SFP_MIN : SFP_MAX;
    end else if (!r_sign && w_pos_ovf) begin
      w_fix_q   = SFP_MAX;
      w_fix_ovf = 1'b1;
    end else if (r_sign && w_neg_ovf) begin
      w_fix_q   = SFP_MIN;
      w_fix_ovf = 1'b1;
    end else begin
      w_fix_q = r_sign ? (~r_q[WIDTH-1:0] + 1'b1) : r_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_bmag  <= '0;
      r_num   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_dz    <= 1'b0;
      out_q   <= '0;
      out_ovf <= 1'b0;
      out_dz  <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (in_valid) begin
            r_a <= in_a;
            r_b <= in_b;
          end
        end
        DIV_SETUP: begin
          r_sign <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
          r_bmag <= mag(r_b);
          r_dz   <= (r_b == '0);
          r_num  <= {mag(r_a), {FRAC_BITS{1'b0}}};
          r_rem  <= '0;
          r_q    <= '0;
          r_cnt  <= CW'(N - 1);
        end
        DIV_DIVIDE: begin
          r_rem <= w_rem_next;
          r_num <= {r_num[N-2:0], 1'b0};
          r_q   <= {r_q[N-2:0], w_qbit};
          r_cnt <= r_cnt - 1'b1;
        end
        DIV_FIX: begin
          out_q   <= w_fix_q;
          out_ovf <= w_fix_ovf;
          out_dz  <= r_dz;
        end
        DIV_DONE: begin
          if (out_ready) begin
            out_q   <= '0;
            out_ovf <= 1'b0;
            out_dz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
